// File: rtl/lcd_ctrl_param_pkg.sv
// Shared types for the image-window controller: command codes, FSM states
// and the positions of the four window pixels inside a packed window vector.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE   = 4'd0,
    CMD_UP      = 4'd1,
    CMD_DOWN    = 4'd2,
    CMD_LEFT    = 4'd3,
    CMD_RIGHT   = 4'd4,
    CMD_MAX     = 4'd5,
    CMD_MIN     = 4'd6,
    CMD_AVG     = 4'd7,
    CMD_ROT_CCW = 4'd8,
    CMD_ROT_CW  = 4'd9,
    CMD_MIR_X   = 4'd10,
    CMD_MIR_Y   = 4'd11,
    CMD_NOP12   = 4'd12,
    CMD_NOP13   = 4'd13,
    CMD_NOP14   = 4'd14,
    CMD_NOP15   = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    IDLE  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // P0=(px-1,py-1) P1=(px,py-1) P2=(px-1,py) P3=(px,py)
  localparam int WIN_P0 = 0;
  localparam int WIN_P1 = 1;
  localparam int WIN_P2 = 2;
  localparam int WIN_P3 = 3;
  localparam int WIN_N  = 4;

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Host / ROM / RAM signal bundle of the image-window controller.
// master = controller side, slave = host and memory side.
interface lcd_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param_win_alu.sv
// Combinational 2x2 window operator: max/min/average/rotate/mirror.
// Macro AVG_ROUND_EN selects round-half-up averaging instead of floor.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]                cmd,
  input  logic [WIN_N-1:0][DW-1:0] win,
  output logic [WIN_N-1:0][DW-1:0] win_new
);

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Sum of four DW-bit values needs DW+2 bits; the +2 bias cannot overflow it.
  function automatic logic [DW-1:0] avg4(input logic [WIN_N-1:0][DW-1:0] w);
    logic [DW+1:0] s;
    s = {2'b00, w[WIN_P0]} + {2'b00, w[WIN_P1]} + {2'b00, w[WIN_P2]} + {2'b00, w[WIN_P3]};
`ifdef AVG_ROUND_EN
    s = s + (DW+2)'(2);
`endif
    return s[DW+1:2];
  endfunction

  logic [DW-1:0] wmax, wmin, wavg;

  always_comb begin
    wmax = max2(max2(win[WIN_P0], win[WIN_P1]), max2(win[WIN_P2], win[WIN_P3]));
    wmin = min2(min2(win[WIN_P0], win[WIN_P1]), min2(win[WIN_P2], win[WIN_P3]));
    wavg = avg4(win);
    win_new = win;
    case (cmd)
      CMD_MAX: win_new = {WIN_N{wmax}};
      CMD_MIN: win_new = {WIN_N{wmin}};
      CMD_AVG: win_new = {WIN_N{wavg}};
      CMD_ROT_CCW: begin
        win_new[WIN_P0] = win[WIN_P1];
        win_new[WIN_P1] = win[WIN_P3];
        win_new[WIN_P3] = win[WIN_P2];
        win_new[WIN_P2] = win[WIN_P0];
      end
      CMD_ROT_CW: begin
        win_new[WIN_P0] = win[WIN_P2];
        win_new[WIN_P2] = win[WIN_P3];
        win_new[WIN_P3] = win[WIN_P1];
        win_new[WIN_P1] = win[WIN_P0];
      end
      CMD_MIR_X: begin
        win_new[WIN_P0] = win[WIN_P2];
        win_new[WIN_P2] = win[WIN_P0];
        win_new[WIN_P1] = win[WIN_P3];
        win_new[WIN_P3] = win[WIN_P1];
      end
      CMD_MIR_Y: begin
        win_new[WIN_P0] = win[WIN_P1];
        win_new[WIN_P1] = win[WIN_P0];
        win_new[WIN_P2] = win[WIN_P3];
        win_new[WIN_P3] = win[WIN_P2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Image-window controller: loads IMG_W x IMG_H pixels from ROM, runs window
// commands around a movable point, streams the image to RAM. Macro: AVG_ROUND_EN.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  lcd_ctrl_param_if.master  bus
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   irom_a_q, iram_a_q;
  logic [XW-1:0]   px_q, px_m1;
  logic [YW-1:0]   py_q, py_m1;
  cmd_e            cmd_q;

  logic [DW-1:0]   img_buf [N];
  logic [WIN_N-1:0][AW-1:0] win_addr;
  logic [WIN_N-1:0][DW-1:0] win, win_new;

  // Power-of-two width makes y*IMG_W + x a plain concatenation.
  always_comb begin
    px_m1 = px_q - XW'(1);
    py_m1 = py_q - YW'(1);
    win_addr[WIN_P0] = {py_m1, px_m1};
    win_addr[WIN_P1] = {py_m1, px_q};
    win_addr[WIN_P2] = {py_q,  px_m1};
    win_addr[WIN_P3] = {py_q,  px_q};
    for (int k = 0; k < WIN_N; k++) win[k] = img_buf[win_addr[k]];
  end

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd     (cmd_q),
    .win     (win),
    .win_new (win_new)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      irom_a_q <= '0;
      iram_a_q <= '0;
      px_q     <= XW'(IMG_W / 2);
      py_q     <= YW'(IMG_H / 2);
      cmd_q    <= CMD_WRITE;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD:  irom_a_q <= (irom_a_q == LAST) ? '0 : irom_a_q + AW'(1);
        IDLE: begin
          iram_a_q <= '0;
          if (bus.cmd_valid) cmd_q <= cmd_e'(bus.cmd);
        end
        EXEC: begin
          case (cmd_q)
            CMD_UP:    if (py_q > YW'(1))         py_q <= py_q - YW'(1);
            CMD_DOWN:  if (py_q < YW'(IMG_H - 1)) py_q <= py_q + YW'(1);
            CMD_LEFT:  if (px_q > XW'(1))         px_q <= px_q - XW'(1);
            CMD_RIGHT: if (px_q < XW'(IMG_W - 1)) px_q <= px_q + XW'(1);
            default: ;
          endcase
        end
        WRITE: iram_a_q <= iram_a_q + AW'(1);
        default: ;
      endcase
    end
  end

  // Pixel storage carries no reset; writes from ROM or the window operator.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      img_buf[irom_a_q] <= bus.IROM_Q;
    end else if (state_q == EXEC) begin
      for (int k = 0; k < WIN_N; k++) img_buf[win_addr[k]] <= win_new[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.busy       = 1'b1;
    bus.IROM_rd    = 1'b0;
    bus.IRAM_valid = 1'b0;
    bus.done       = 1'b0;
    bus.IROM_A     = irom_a_q;
    bus.IRAM_A     = iram_a_q;
    bus.IRAM_D     = '0;
    case (state_q)
      LOAD: begin
        bus.IROM_rd = 1'b1;
        if (irom_a_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.cmd_valid) state_d = (bus.cmd == CMD_WRITE) ? WRITE : EXEC;
      end
      EXEC: state_d = IDLE;
      WRITE: begin
        bus.IRAM_valid = 1'b1;
        bus.IRAM_D     = img_buf[iram_a_q];
        if (iram_a_q == LAST) state_d = DONE;
      end
      DONE: bus.done = 1'b1;
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param, 8x8 image, ROM pixel[i] = i.
module tb_lcd_ctrl_param;
  import lcd_ctrl_pkg::*;

  localparam int N = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  lcd_ctrl_param_if #(.DW(8), .AW(6)) bus();

  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.IROM_Q = {2'b00, bus.IROM_A};

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] cap     [N];
  logic [7:0] exp_img [N];
  int         cap_cnt;
  logic       seq_ok;

  function automatic int first_bad();
    for (int i = 0; i < N; i++) if (cap[i] !== exp_img[i]) return i;
    return -1;
  endfunction

  task automatic init_exp();
    for (int i = 0; i < N; i++) exp_img[i] = 8'(i);
  endtask

  task automatic load_image();
    int t;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t = 0;
    while (bus.busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL load_timeout busy=%b required 0", bus.busy);
    else n_pass++;
  endtask

  task automatic send(input logic [3:0] c);
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_capture();
    for (int i = 0; i < N; i++) cap[i] = 8'hxx;
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cap_cnt = 0;
    seq_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bus.IRAM_valid === 1'b1 && bus.IRAM_A === i[5:0]) begin
        cap[i] = bus.IRAM_D;
        cap_cnt++;
      end else begin
        seq_ok = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic ok;
    #2 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.IROM_A !== 6'd0 || bus.IRAM_A !== 6'd0 || bus.IRAM_D !== 8'd0)
      $display("FAIL reset_addr IROM_A=%0d IRAM_A=%0d IRAM_D=%0d required 0/0/0",
               bus.IROM_A, bus.IRAM_A, bus.IRAM_D);
    else n_pass++;
    n_checks++;
    if (bus.IRAM_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.IROM_rd !== 1'b1)
      $display("FAIL reset_ctrl valid=%b done=%b busy=%b rd=%b required 0/0/1/1",
               bus.IRAM_valid, bus.done, bus.busy, bus.IROM_rd);
    else n_pass++;
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
    reset = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (bus.IROM_A !== c[5:0] || bus.IROM_rd !== 1'b1 || bus.busy !== 1'b1) begin
        if (ok) $display("FAIL load_seq cycle=%0d IROM_A=%0d rd=%b busy=%b required %0d/1/1",
                         c, bus.IROM_A, bus.IROM_rd, bus.busy, c);
        ok = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (ok) n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.IROM_rd !== 1'b0 || bus.IROM_A !== 6'd0)
      $display("FAIL load_end busy=%b rd=%b IROM_A=%0d required 0/0/0",
               bus.busy, bus.IROM_rd, bus.IROM_A);
    else n_pass++;
  endtask

  task automatic test_max();
    int fb;
    load_image();
    bus.cmd = 4'd5;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL exec_busy busy=%b required 1", bus.busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL exec_release busy=%b required 0", bus.busy);
    else n_pass++;
    write_capture();
    init_exp();
    exp_img[27] = 36; exp_img[28] = 36; exp_img[35] = 36; exp_img[36] = 36;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL max_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_clamp_left_min();
    int fb;
    load_image();
    repeat (5) send(4'd3);
    send(4'd6);
    write_capture();
    init_exp();
    exp_img[24] = 24; exp_img[25] = 24; exp_img[32] = 24; exp_img[33] = 24;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL clamp_min_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_clamp_corner_max();
    int fb;
    load_image();
    repeat (5) send(4'd4);
    repeat (5) send(4'd2);
    send(4'd5);
    write_capture();
    init_exp();
    exp_img[54] = 63; exp_img[55] = 63; exp_img[62] = 63; exp_img[63] = 63;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL corner_max_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_avg();
    int fb;
    logic [7:0] a;
`ifdef AVG_ROUND_EN
    a = 8'd32;
`else
    a = 8'd31;
`endif
    load_image();
    send(4'd7);
    write_capture();
    init_exp();
    exp_img[27] = a; exp_img[28] = a; exp_img[35] = a; exp_img[36] = a;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL avg_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_rotate();
    int fb;
    load_image();
    send(4'd9);
    write_capture();
    init_exp();
    exp_img[27] = 35; exp_img[28] = 27; exp_img[36] = 28; exp_img[35] = 36;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL rot_cw_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
    load_image();
    send(4'd9);
    send(4'd8);
    write_capture();
    init_exp();
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL rot_restore_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_mirror_up_nop();
    int fb;
    load_image();
    send(4'd1);
    send(4'd10);
    send(4'd13);
    send(4'd11);
    write_capture();
    init_exp();
    // point (4,3): P0=19 P1=20 P2=27 P3=28; mirror X then mirror Y
    exp_img[19] = 28; exp_img[20] = 27; exp_img[27] = 20; exp_img[28] = 19;
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL mirror_image addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
  endtask

  task automatic test_write_done();
    int fb;
    logic ok;
    load_image();
    write_capture();
    n_checks++;
    if (cap_cnt !== N || !seq_ok) $display("FAIL write_seq count=%0d in_order=%b required 64/1", cap_cnt, seq_ok);
    else n_pass++;
    init_exp();
    fb = first_bad();
    n_checks++;
    if (fb >= 0) $display("FAIL write_data addr=%0d got=%0d required=%0d", fb, cap[fb], exp_img[fb]);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b1 || bus.IRAM_valid !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL done_state done=%b valid=%b busy=%b required 1/0/1", bus.done, bus.IRAM_valid, bus.busy);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.cmd = (i % 2 == 0) ? 4'd0 : 4'd5;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      if (bus.done !== 1'b1 || bus.IRAM_valid !== 1'b0) ok = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL done_sticky done=%b valid=%b required 1/0", bus.done, bus.IRAM_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    load_image();
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.IRAM_valid !== 1'b1 || bus.IRAM_A !== 6'd20)
      $display("FAIL write_cycle20 valid=%b IRAM_A=%0d required 1/20", bus.IRAM_valid, bus.IRAM_A);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.IRAM_valid !== 1'b0 || bus.IROM_A !== 6'd0 || bus.IROM_rd !== 1'b1)
      $display("FAIL abort_write done=%b valid=%b IROM_A=%0d rd=%b required 0/0/0/1",
               bus.done, bus.IRAM_valid, bus.IROM_A, bus.IROM_rd);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.IROM_A !== 6'd1 || bus.busy !== 1'b1)
      $display("FAIL reload_start IROM_A=%0d busy=%b required 1/1", bus.IROM_A, bus.busy);
    else n_pass++;
  endtask

  initial begin
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    test_reset();
    test_max();
    test_clamp_left_min();
    test_clamp_corner_max();
    test_avg();
    test_rotate();
    test_mirror_up_nop();
    test_write_done();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
